// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the instruction/data memory port arbiter:
//   - arb_state_e : arbiter FSM states (IDLE=0, BUSY_I=1, BUSY_D=2, RESP=3)
//   - OWNER_*     : encodings driven on the debug owner output
//   - DEFAULT_*   : default values for the MAX_D_STREAK and TIMEOUT parameters
//   - PORT_*      : indices of the per-requester read-data registers
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE  = 2'b00;
  localparam logic [1:0] OWNER_FETCH = 2'b01;
  localparam logic [1:0] OWNER_DATA  = 2'b10;

  localparam int DEFAULT_MAX_D_STREAK = 3;
  localparam int DEFAULT_TIMEOUT      = 15;

  // Data-grant streak counter width; it saturates at all-ones.
  localparam int                  STREAK_W   = 3;
  localparam logic [STREAK_W-1:0] STREAK_MAX = '1;

  localparam int PORT_COUNT = 2;
  localparam int PORT_FETCH = 0;
  localparam int PORT_DATA  = 1;

endpackage

// File: rtl/arb_timeout_ctr.sv
// arb_timeout_ctr
// Loadable down-counter that bounds how long an access may wait for mem_ready.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   load       : reload the counter with TIMEOUT (asserted on the grant edge)
//   dec        : count one waiting cycle (BUSY with mem_ready=0)
//   expire     : the current waiting cycle is the one whose edge takes the
//                count to zero, i.e. the access has waited TIMEOUT cycles
module arb_timeout_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CW'(TIMEOUT);
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  // Expiry is flagged combinationally in the cycle that decrements to zero so
  // the FSM leaves BUSY after exactly TIMEOUT waiting cycles, not TIMEOUT+1.
  assign expire = dec && (count_reg == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates one single-ported memory between an instruction-fetch requester
// and a data requester. Data normally wins, but after MAX_D_STREAK consecutive
// data grants with a fetch waiting, the fetch is forced through. Each access
// runs IDLE -> BUSY_x -> RESP -> IDLE; an access that sees no mem_ready for
// TIMEOUT cycles is completed with err=1 and zero read data.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   i_req/i_addr/i_ack/i_rdata  : fetch request handshake and read data
//   d_req/d_we/d_addr/d_wdata   : data request, write enable, address, data
//   d_ack/d_rdata               : data completion pulse and load data
//   err                         : with an ack, 1 = access timed out
//   mem_en/mem_we               : memory request and write strobe
//   mem_addr/mem_wdata          : registered memory address and write data
//   mem_rdata/mem_ready         : memory read data and completion
//   owner                       : debug, 00 none / 01 fetch / 10 data
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = DEFAULT_MAX_D_STREAK,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [1:0]  owner
);

  arb_state_e          state_reg;
  arb_state_e          state_next;
  logic [STREAK_W-1:0] streak_reg;
  logic                data_owner_reg;
  logic                we_reg;
  logic                err_reg;
  logic [31:0]         addr_reg;
  logic [31:0]         wdata_reg;
  logic [31:0]         rdata_reg [PORT_COUNT];

  logic                  busy;
  logic                  streak_full;
  logic                  grant;
  logic                  grant_data;
  logic                  access_done;
  logic                  timeout_expire;
  logic [PORT_COUNT-1:0] capture;

  assign busy        = (state_reg == BUSY_I) || (state_reg == BUSY_D);
  assign streak_full = (32'(streak_reg) == MAX_D_STREAK);
  // Data wins unless the streak is used up and a fetch is waiting.
  assign grant_data  = d_req && !(i_req && streak_full);
  assign grant       = (state_reg == IDLE) && (i_req || d_req);
  assign access_done = busy && (mem_ready || timeout_expire);

  arb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .load  (grant),
    .dec   (busy && !mem_ready),
    .expire(timeout_expire)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant) begin
          state_next = grant_data ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready || timeout_expire) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_en = 1'b0;
    mem_we = 1'b0;
    i_ack  = 1'b0;
    d_ack  = 1'b0;
    err    = 1'b0;
    owner  = OWNER_NONE;
    case (state_reg)
      BUSY_I: begin
        mem_en = 1'b1;
        owner  = OWNER_FETCH;
      end
      BUSY_D: begin
        mem_en = 1'b1;
        mem_we = we_reg;
        owner  = OWNER_DATA;
      end
      RESP: begin
        i_ack = !data_owner_reg;
        d_ack = data_owner_reg;
        err   = err_reg;
        owner = data_owner_reg ? OWNER_DATA : OWNER_FETCH;
      end
      default: ;
    endcase
  end

  // Grant-time capture of the winning request, plus the streak counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_reg     <= '0;
      data_owner_reg <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      err_reg        <= 1'b0;
    end else begin
      if (grant) begin
        data_owner_reg <= grant_data;
        addr_reg       <= grant_data ? d_addr : i_addr;
        wdata_reg      <= grant_data ? d_wdata : '0;
        we_reg         <= grant_data && d_we;
        // Only a data grant that bypassed a waiting fetch extends the streak.
        if (grant_data && i_req) begin
          streak_reg <= (streak_reg == STREAK_MAX) ? streak_reg
                                                   : streak_reg + STREAK_W'(1);
        end else begin
          streak_reg <= '0;
        end
      end
      if (access_done) begin
        err_reg <= !mem_ready;
      end
    end
  end

  // One read-data register per requester; only the owner's is written.
  genvar gi;
  generate
    for (gi = 0; gi < PORT_COUNT; gi++) begin : g_capture
      assign capture[gi] = access_done && (data_owner_reg == (gi == PORT_DATA));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        rdata_reg[p] <= '0;
      end
    end else begin
      for (int p = 0; p < PORT_COUNT; p++) begin
        if (capture[p]) begin
          rdata_reg[p] <= mem_ready ? mem_rdata : '0;
        end
      end
    end
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign i_rdata   = rdata_reg[PORT_FETCH];
  assign d_rdata   = rdata_reg[PORT_DATA];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios followed by a randomized run. A behavioural memory
// (associative array) answers accesses with configurable latency, and a
// transaction-level arbitration model predicts every grant and ack.
module tb_mem_port_arbiter;

  localparam int         MAX_D_STREAK = 3;
  localparam int         TIMEOUT      = 15;
  localparam logic [1:0] OWN_N        = 2'b00;
  localparam logic [1:0] OWN_F        = 2'b01;
  localparam logic [1:0] OWN_D        = 2'b10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req, d_req, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_ack, d_ack, err, mem_en, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]  owner;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .err      (err),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .owner    (owner)
  );

  // ---------------- behavioural memory ----------------
  logic [31:0] mem_model [logic [31:0]];
  int ready_delay = 0;
  bit ready_never = 1'b0;
  bit rand_lat    = 1'b0;
  bit spurious    = 1'b0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  initial begin
    int busy_cnt;
    int cur_delay;
    busy_cnt  = 0;
    cur_delay = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        if (busy_cnt == 0) cur_delay = rand_lat ? int'($urandom_range(0, 3)) : ready_delay;
        if (!ready_never && busy_cnt == cur_delay) begin
          mem_ready = 1'b1;
          mem_rdata = mem_read(mem_addr);
          if (mem_we) mem_model[mem_addr] = mem_wdata;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
        busy_cnt++;
      end else begin
        busy_cnt  = 0;
        mem_ready = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_en, mem_we, i_ack, d_ack, err, owner} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000000", {mem_en, mem_we, i_ack, d_ack, err, owner});
    end
    n_checks++;
    if ((mem_addr | mem_wdata | i_rdata | d_rdata) !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h irdata=%h drdata=%h expected all 0", mem_addr, mem_wdata, i_rdata, d_rdata);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (mem_en !== 1'b0 || owner !== OWN_N) begin
      n_fail++;
      $display("FAIL idle_no_req: mem_en=%b owner=%b expected 0/00", mem_en, owner);
    end
  endtask

  task automatic test_single_fetch();
    mem_model[32'h100] = 32'hE3A0_0001;
    ready_delay = 0;
    i_req = 1; i_addr = 32'h100;
    tick();
    n_checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || owner !== OWN_F || i_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_busy: en=%b we=%b addr=%h owner=%b ack=%b expected 1/0/100/01/0", mem_en, mem_we, mem_addr, owner, i_ack);
    end
    tick();
    n_checks++;
    if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== 32'hE3A0_0001 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_ack: i_ack=%b d_ack=%b rdata=%h err=%b expected 1/0/e3a00001/0", i_ack, d_ack, i_rdata, err);
    end
    $display("txn fetch addr=%h rdata=%h err=%b", i_addr, i_rdata, err);
    i_req = 0;
    tick();
    n_checks++;
    if (i_ack !== 1'b0 || owner !== OWN_N || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_done: i_ack=%b owner=%b mem_en=%b expected 0/00/0", i_ack, owner, mem_en);
    end
  endtask

  task automatic test_simultaneous();
    int ack_cyc;
    i_req = 1; i_addr = 32'h104;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    tick();
    n_checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF || owner !== OWN_D) begin
      n_fail++;
      $display("FAIL simul_data_first: en=%b we=%b addr=%h wdata=%h owner=%b expected 1/1/200/deadbeef/10", mem_en, mem_we, mem_addr, mem_wdata, owner);
    end
    tick();
    n_checks++;
    if (d_ack !== 1'b1 || i_ack !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_d_ack: d_ack=%b i_ack=%b err=%b expected 1/0/0", d_ack, i_ack, err);
    end
    $display("txn store addr=%h wdata=%h err=%b", d_addr, d_wdata, err);
    d_req = 0; d_we = 0;
    ack_cyc = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (i_ack) begin
        ack_cyc = c;
        break;
      end
    end
    n_checks++;
    if (ack_cyc != 3 || i_rdata !== mem_read(32'h104)) begin
      n_fail++;
      $display("FAIL simul_fetch_later: fetch ack %0d cycles after data ack, rdata=%h expected 3 and %h", ack_cyc, i_rdata, mem_read(32'h104));
    end
    $display("txn fetch addr=%h rdata=%h err=%b", i_addr, i_rdata, err);
    i_req = 0;
    tick();
  endtask

  task automatic test_streak();
    string seq;
    int    acks;
    int    cyc;
    seq = "";
    acks = 0;
    cyc = 0;
    i_req = 1; i_addr = 32'h180;
    d_req = 1; d_we = 0; d_addr = 32'h200;
    while (acks < 6 && cyc < 60) begin
      tick();
      cyc++;
      if (d_ack) begin
        seq = {seq, "D"};
        n_checks++;
        if (d_rdata !== mem_read(d_addr) || (acks == 0 && d_rdata !== 32'hDEAD_BEEF)) begin
          n_fail++;
          $display("FAIL streak_load_data: addr=%h got %h expected %h", d_addr, d_rdata, mem_read(d_addr));
        end
        $display("txn load addr=%h rdata=%h err=%b", d_addr, d_rdata, err);
        acks++;
        d_addr = 32'h200 + 32'(4 * acks);
      end
      if (i_ack) begin
        seq = {seq, "I"};
        n_checks++;
        if (i_rdata !== mem_read(i_addr)) begin
          n_fail++;
          $display("FAIL streak_fetch_data: got %h expected %h", i_rdata, mem_read(i_addr));
        end
        $display("txn fetch addr=%h rdata=%h err=%b", i_addr, i_rdata, err);
        acks++;
        i_req = 0;
      end
    end
    d_req = 0;
    n_checks++;
    if (seq != "DDDIDD") begin
      n_fail++;
      $display("FAIL streak_order: got %s expected DDDIDD (cycles=%0d)", seq, cyc);
    end
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int busy;
    bit got;
    bit addr_ok;
    busy = 0; got = 0; addr_ok = 1;
    ready_never = 1;
    d_req = 1; d_we = 0; d_addr = 32'h300;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (d_ack) begin
        got = 1;
        break;
      end
      if (mem_en) begin
        busy++;
        if (mem_addr !== 32'h300) addr_ok = 0;
      end
    end
    n_checks++;
    if (!got || busy != TIMEOUT || !addr_ok) begin
      n_fail++;
      $display("FAIL timeout_len: ack=%0d busy_cycles=%0d addr_stable=%0d expected 1/%0d/1", got, busy, addr_ok, TIMEOUT);
    end
    n_checks++;
    if (err !== 1'b1 || d_rdata !== 32'h0 || owner !== OWN_D) begin
      n_fail++;
      $display("FAIL timeout_resp: err=%b rdata=%h owner=%b expected 1/0/10", err, d_rdata, owner);
    end
    $display("txn load addr=%h rdata=%h err=%b", d_addr, d_rdata, err);
    d_req = 0;
    ready_never = 0;
    tick();
    n_checks++;
    if (err !== 1'b0 || d_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: err=%b d_ack=%b expected 0/0", err, d_ack);
    end
  endtask

  task automatic test_reset_mid_busy();
    int stray;
    ready_never = 1;
    d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'h1234_5678;
    tick();
    n_checks++;
    if (mem_en !== 1'b1 || owner !== OWN_D) begin
      n_fail++;
      $display("FAIL rst_busy_entry: mem_en=%b owner=%b expected 1/10", mem_en, owner);
    end
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_en, mem_we, i_ack, d_ack, err, owner} !== 7'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_async: ctrl=%b addr=%h wdata=%h expected 0/0/0", {mem_en, mem_we, i_ack, d_ack, err, owner}, mem_addr, mem_wdata);
    end
    d_req = 0; d_we = 0;
    ready_never = 0;
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_first_cycle: mem_en=%b expected 0", mem_en);
    end
    stray = 0;
    repeat (10) begin
      tick();
      if (d_ack || i_ack || mem_en) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL rst_no_ack: %0d cycles with activity expected 0", stray);
    end
    i_req = 1; i_addr = 32'h140;
    tick();
    n_checks++;
    if (mem_en !== 1'b1 || owner !== OWN_F || mem_addr !== 32'h140) begin
      n_fail++;
      $display("FAIL rst_clean_grant: en=%b owner=%b addr=%h expected 1/01/140", mem_en, owner, mem_addr);
    end
    tick();
    n_checks++;
    if (i_ack !== 1'b1 || i_rdata !== mem_read(32'h140) || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_clean_ack: ack=%b rdata=%h err=%b expected 1/%h/0", i_ack, i_rdata, err, mem_read(32'h140));
    end
    $display("txn fetch addr=%h rdata=%h err=%b", i_addr, i_rdata, err);
    i_req = 0;
    tick();
  endtask

  task automatic test_hold_resp();
    d_req = 1; d_we = 0; d_addr = 32'h500;
    tick();
    tick();
    n_checks++;
    if (d_ack !== 1'b1 || d_rdata !== mem_read(32'h500)) begin
      n_fail++;
      $display("FAIL hold_ack: d_ack=%b rdata=%h expected 1/%h", d_ack, d_rdata, mem_read(32'h500));
    end
    $display("txn load addr=%h rdata=%h err=%b", d_addr, d_rdata, err);
    // d_req stays high through RESP and a fetch appears; RESP must ignore both.
    i_req = 1; i_addr = 32'h540;
    tick();
    n_checks++;
    if (mem_en !== 1'b0 || d_ack !== 1'b0 || owner !== OWN_N) begin
      n_fail++;
      $display("FAIL hold_no_dup: mem_en=%b d_ack=%b owner=%b expected 0/0/00", mem_en, d_ack, owner);
    end
    d_req = 0;
    tick();
    n_checks++;
    if (mem_en !== 1'b1 || owner !== OWN_F || mem_addr !== 32'h540) begin
      n_fail++;
      $display("FAIL hold_rearb: en=%b owner=%b addr=%h expected 1/01/540", mem_en, owner, mem_addr);
    end
    tick();
    n_checks++;
    if (i_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_fetch_ack: i_ack=%b expected 1", i_ack);
    end
    $display("txn fetch addr=%h rdata=%h err=%b", i_addr, i_rdata, err);
    i_req = 0;
    tick();
  endtask

  task automatic test_random();
    int          streak_m;
    bit          owner_d;
    bit          in_flight;
    bit          prev_en;
    bit          smp_i;
    bit          smp_d;
    bit          exp_d;
    int          grants;
    int          acks_n;
    logic [31:0] exp_rdata;
    streak_m = 0; owner_d = 0; in_flight = 0; prev_en = 0;
    grants = 0; acks_n = 0; exp_rdata = '0;
    rand_lat = 1; spurious = 1;
    for (int c = 0; c < 3000 && acks_n < 200; c++) begin
      smp_i = i_req;
      smp_d = d_req;
      tick();
      if (mem_en && !prev_en) begin
        grants++;
        exp_d = smp_d && !(smp_i && streak_m == MAX_D_STREAK);
        n_checks++;
        if (!(smp_i || smp_d) || owner !== (exp_d ? OWN_D : OWN_F) || in_flight) begin
          n_fail++;
          $display("FAIL rnd_winner: owner=%b expected %b (i=%0d d=%0d streak=%0d)", owner, exp_d ? OWN_D : OWN_F, smp_i, smp_d, streak_m);
        end
        n_checks++;
        if (exp_d ? (mem_addr !== d_addr || mem_we !== d_we || (d_we && mem_wdata !== d_wdata))
                  : (mem_addr !== i_addr || mem_we !== 1'b0)) begin
          n_fail++;
          $display("FAIL rnd_access: addr=%h we=%b wdata=%h for %s request", mem_addr, mem_we, mem_wdata, exp_d ? "data" : "fetch");
        end
        if (exp_d) begin
          streak_m = smp_i ? ((streak_m == 7) ? 7 : streak_m + 1) : 0;
          exp_rdata = mem_read(d_addr);
        end else begin
          streak_m = 0;
          exp_rdata = mem_read(i_addr);
        end
        owner_d = exp_d;
        in_flight = 1;
      end
      prev_en = mem_en;
      if (i_ack || d_ack) begin
        acks_n++;
        n_checks++;
        if (!in_flight || (i_ack && d_ack) || d_ack !== owner_d || err !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_ack: i_ack=%b d_ack=%b err=%b expected %s ack, err 0", i_ack, d_ack, err, owner_d ? "data" : "fetch");
        end
        if (i_ack) begin
          n_checks++;
          if (i_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL rnd_fetch_data: addr=%h got %h expected %h", i_addr, i_rdata, exp_rdata);
          end
          $display("txn fetch addr=%h rdata=%h err=%b", i_addr, i_rdata, err);
          i_req = 0;
        end
        if (d_ack) begin
          if (!d_we) begin
            n_checks++;
            if (d_rdata !== exp_rdata) begin
              n_fail++;
              $display("FAIL rnd_load_data: addr=%h got %h expected %h", d_addr, d_rdata, exp_rdata);
            end
            $display("txn load addr=%h rdata=%h err=%b", d_addr, d_rdata, err);
          end else begin
            $display("txn store addr=%h wdata=%h err=%b", d_addr, d_wdata, err);
          end
          d_req = 0;
        end
        in_flight = 0;
      end else begin
        if (!i_req && $urandom_range(0, 2) == 0) begin
          i_req = 1;
          i_addr = 32'h1000 + 32'(4 * $urandom_range(0, 15));
        end
        if (!d_req && $urandom_range(0, 1) == 0) begin
          d_req = 1;
          d_we = 1'($urandom_range(0, 1));
          d_addr = 32'h1000 + 32'(4 * $urandom_range(0, 15));
          d_wdata = $urandom;
        end
      end
    end
    n_checks++;
    if (acks_n != 200 || grants != acks_n) begin
      n_fail++;
      $display("FAIL rnd_progress: acks=%0d grants=%0d expected 200/200", acks_n, grants);
    end
    rand_lat = 0; spurious = 0;
    i_req = 0; d_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_streak();
    test_timeout();
    test_reset_mid_busy();
    test_hold_resp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
